// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared state and bus encodings for the burst memory controller.
// Imported by burst_mem_ctrl and its testbench.
package memctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/memctrl_ram.sv
// memctrl_ram: single-page word memory, combinational read port and
// synchronous write port. Contents survive controller reset.
module memctrl_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/burst_mem_ctrl.sv
// burst_mem_ctrl: multiplexed address/data bus burst memory controller.
// Define MEMCTRL_WRAP_EN for critical-word-first wrapping bursts.
module burst_mem_ctrl
  import memctrl_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PAGE_BITS = 12,
  parameter logic [DATA_W-PAGE_BITS-1:0] PAGE_ID = 4'h0,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              addrValid,
  input  logic              rw,
  input  logic [DATA_W-1:0] addrData_in,
  output logic [DATA_W-1:0] addrData_out,
  output logic              addrData_oe,
  output logic              busy
);

  localparam int CNT_W =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PAGE_BITS-1:0] BLK_MASK =
    PAGE_BITS'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BURST_LEN - 1);

  function automatic logic [PAGE_BITS-1:0] burst_addr(
    input logic [PAGE_BITS-1:0] a,
    input logic [PAGE_BITS-1:0] k
  );
`ifdef MEMCTRL_WRAP_EN
    return (a & ~BLK_MASK) | ((a + k) & BLK_MASK);
`else
    return a + k;
`endif
  endfunction

  state_e state, state_nx;

  logic [PAGE_BITS-1:0] base;
  logic [CNT_W-1:0]     cnt;
  logic [PAGE_BITS-1:0] rd_base;
  logic [PAGE_BITS-1:0] rd_off;
  logic [PAGE_BITS-1:0] rd_addr;
  logic [PAGE_BITS-1:0] wr_addr;
  logic [DATA_W-1:0]    rd_data;
  logic [DATA_W-1:0]    out_q;
  logic                 oe_q;
  logic                 hit;
  logic                 last;
  logic                 load;
  logic                 wr_en;

  assign hit  = addrValid &&
    (addrData_in[DATA_W-1:PAGE_BITS] == PAGE_ID);
  assign last = (cnt == CNT_LAST);

  // In T(k) the read port fetches word k so it lands in T(k+1).
  always_comb begin
    state_nx = state;
    rd_base  = addrData_in[PAGE_BITS-1:0];
    rd_off   = '0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_nx = (rw == RW_WRITE) ? WRITE : READ;
          load     = (rw == RW_READ);
        end
      end
      READ: begin
        rd_base = base;
        rd_off  = PAGE_BITS'(cnt) + PAGE_BITS'(1);
        load    = !last;
        if (last) state_nx = IDLE;
      end
      WRITE: begin
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_addr = burst_addr(rd_base, rd_off);
  assign wr_addr = burst_addr(base, PAGE_BITS'(cnt));
  // Reset on the same edge suppresses the write.
  assign wr_en   = (state == WRITE) && resetN;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      base  <= '0;
      cnt   <= '0;
      out_q <= '0;
      oe_q  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
        if (hit) base <= addrData_in[PAGE_BITS-1:0];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      oe_q  <= load;
      out_q <= load ? rd_data : '0;
    end
  end

  memctrl_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (PAGE_BITS)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (addrData_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign addrData_out = out_q;
  assign addrData_oe  = oe_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// tb_burst_mem_ctrl: scoreboard bench for burst_mem_ctrl at default
// parameters (16-bit bus, 4K page, PAGE_ID 0, bursts of 4).
module tb_burst_mem_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        addrValid;
  logic        rw;
  logic [15:0] addrData_in;
  logic [15:0] addrData_out;
  logic        addrData_oe;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [15:0] ref_mem [4096];
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  burst_mem_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .addrValid    (addrValid),
    .rw           (rw),
    .addrData_in  (addrData_in),
    .addrData_out (addrData_out),
    .addrData_oe  (addrData_oe),
    .busy         (busy)
  );

  function automatic logic [11:0] baddr(input logic [11:0] a, input int k);
`ifdef MEMCTRL_WRAP_EN
    logic [1:0] lo;
    lo = a[1:0] + 2'(k);
    return {a[11:2], lo};
`else
    return a + 12'(k);
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (addrData_oe === 1'b1) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_oe out=%h want no read data", addrData_out);
        end else begin
          logic [15:0] exp;
          exp = sb.pop_front();
          if (addrData_out !== exp) begin
            n_err++;
            $display("FAIL rd_data got=%h want=%h", addrData_out, exp);
          end
        end
      end else if (addrData_out !== 16'h0) begin
        n_err++;
        $display("FAIL out_idle got=%h want=0000", addrData_out);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [15:0] a, input logic [15:0] d0);
    addrValid = 1'b1; rw = 1'b0; addrData_in = a;
    step;
    addrValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addrData_in = d0 + 16'(k);
      ref_mem[baddr(a[11:0], k)] = d0 + 16'(k);
      n_vec++;
      if (busy !== 1'b1 || addrData_oe !== 1'b0) begin
        n_err++;
        $display("FAIL wr_busy a=%h T%0d busy=%b oe=%b want 1/0",
                 a, k + 1, busy, addrData_oe);
      end
      step;
    end
    addrData_in = '0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wr_done a=%h busy=%b want 0", a, busy);
    end
  endtask

  task automatic read_burst(input logic [15:0] a);
    addrValid = 1'b1; rw = 1'b1; addrData_in = a;
    for (int k = 0; k < 4; k++) sb.push_back(ref_mem[baddr(a[11:0], k)]);
    step;
    addrValid = 1'b0; addrData_in = '0;
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if (busy !== 1'b1 || addrData_oe !== 1'b1) begin
        n_err++;
        $display("FAIL rd_oe a=%h T%0d busy=%b oe=%b want 1/1",
                 a, k, busy, addrData_oe);
      end
      step;
    end
    n_vec++;
    if (busy !== 1'b0 || addrData_oe !== 1'b0) begin
      n_err++;
      $display("FAIL rd_done a=%h busy=%b oe=%b want 0/0",
               a, busy, addrData_oe);
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0; addrValid = 1'b0; rw = 1'b0; addrData_in = '0;
    step;
    step;
    n_vec++;
    if (busy !== 1'b0 || addrData_oe !== 1'b0 || addrData_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset busy=%b oe=%b out=%h want 0/0/0000",
               busy, addrData_oe, addrData_out);
    end
    resetN = 1'b1;
    step;
  endtask

  task automatic test_write_read;
    write_burst(16'h0010, 16'hA000);
    read_burst(16'h0010);
    write_burst(16'h0014, 16'hA004);
    read_burst(16'h0014);
  endtask

  task automatic test_wrap;
    read_burst(16'h0012);
  endtask

  task automatic test_page_edge;
    write_burst(16'h0FFC, 16'hD000);
    write_burst(16'h0000, 16'hE000);
    read_burst(16'h0FFE);
  endtask

  task automatic test_nomatch;
    write_burst(16'h0234, 16'hF000);
    for (int r = 0; r < 2; r++) begin
      addrValid = 1'b1; rw = r[0]; addrData_in = 16'h1234;
      step;
      addrValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        addrData_in = 16'h5555;
        n_vec++;
        if (busy !== 1'b0 || addrData_oe !== 1'b0) begin
          n_err++;
          $display("FAIL nomatch rw=%0d busy=%b oe=%b want 0/0",
                   r, busy, addrData_oe);
        end
        step;
      end
    end
    addrData_in = '0;
    read_burst(16'h0234);
  endtask

  task automatic test_reset_mid;
    write_burst(16'h0040, 16'hB040);
    addrValid = 1'b1; rw = 1'b0; addrData_in = 16'h0040;
    step;
    addrValid = 1'b0; addrData_in = 16'hC000;
    ref_mem[12'h040] = 16'hC000;
    step;
    addrData_in = 16'hC001; resetN = 1'b0;
    step;
    resetN = 1'b1; addrData_in = 16'hC002;
    n_vec++;
    if (busy !== 1'b0 || addrData_oe !== 1'b0 || addrData_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid busy=%b oe=%b out=%h want 0/0/0000",
               busy, addrData_oe, addrData_out);
    end
    step;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle busy=%b want 0", busy);
    end
    addrData_in = '0;
    read_burst(16'h0040);
  endtask

  task automatic test_back_to_back;
    addrValid = 1'b1; rw = 1'b1; addrData_in = 16'h0010;
    for (int k = 0; k < 4; k++) sb.push_back(ref_mem[baddr(12'h010, k)]);
    step;
    addrValid = 1'b0;
    step;
    addrValid = 1'b1; rw = 1'b0; addrData_in = 16'h0020;
    step;
    addrValid = 1'b0; rw = 1'b1; addrData_in = 16'h7777;
    n_vec++;
    if (busy !== 1'b1 || addrData_oe !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_t3 busy=%b oe=%b want 1/1", busy, addrData_oe);
    end
    step;
    step;
    read_burst(16'h0014);
    read_burst(16'h0010);
  endtask

  initial begin
    test_reset;
    mon_en = 1'b1;
    test_write_read;
    test_wrap;
    test_page_edge;
    test_nomatch;
    test_reset_mid;
    test_back_to_back;
    step;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain left=%0d want 0", sb.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/burst_mem_ctrl.md
BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of the multiplexed addrData bus; the address is carried in the full DATA_W.
REQ-002 SHALL have parameter PAGE_BITS, default 12: log2 of words held; memory depth is 2**PAGE_BITS words of DATA_W bits.
REQ-003 SHALL have parameter PAGE_ID, default 4'h0: value of address bits [DATA_W-1:PAGE_BITS] that selects this controller.
REQ-004 SHALL have parameter BURST_LEN, default 4: data words per transaction, a power of two, 1..16.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port resetN  input  1  synchronous active-low reset.
REQ-007 SHALL have port addrValid  input  1  high for one cycle marks an address cycle.
REQ-008 SHALL have port rw  input  1  sampled in the address cycle; 1=read, 0=write.
REQ-009 SHALL have port addrData_in  input  DATA_W  bus value: address in the address cycle, write data in write data cycles.
REQ-010 SHALL have port addrData_out  output  DATA_W  read data driven toward the bus.
REQ-011 SHALL have port addrData_oe  output  1  high only while addrData_out is valid read data.
REQ-012 SHALL have port busy  output  1  high while a burst is in progress.

Function
REQ-013 SHALL implement states IDLE, READ, WRITE; IDLE->READ/WRITE on an address cycle whose upper address bits equal PAGE_ID; otherwise remain in IDLE.
REQ-014 SHALL latch the word address (low PAGE_BITS bits) and rw in the address cycle T0; the burst counter starts at 0.
REQ-015 SHALL, for a read, drive addrData_oe=1 and the data word k in cycle T(1+k), k=0..BURST_LEN-1; the word is loaded into the output register on the edge ending cycle T(k).
REQ-016 SHALL, for a write, write addrData_in to memory on the edge ending cycle T(1+k), k=0..BURST_LEN-1.
REQ-017 SHALL return to IDLE on the edge ending cycle T(BURST_LEN); busy is high in T1..T(BURST_LEN) only.
REQ-018 SHALL ignore addrValid while busy; no new transaction is queued.
REQ-019 SHALL accept a new address cycle in T(BURST_LEN+1), giving back-to-back bursts with no dead cycle.
REQ-020 SHALL compute the burst address with modulo-2**PAGE_BITS arithmetic; it never leaves the page.
REQ-021 SHALL hold addrData_out at all-zeros whenever addrData_oe is 0.
REQ-022 SHALL never assert addrData_oe during a write or for a non-matching address.

Reset
REQ-023 SHALL, when resetN=0 on a clock edge, enter IDLE and drive busy=0, addrData_oe=0, addrData_out=0 from the next cycle.
REQ-024 SHALL abort a burst when reset occurs mid-burst; words already written remain, and no further writes occur.
REQ-025 SHALL NOT clear the memory array on reset.

Configuration
REQ-026 SHALL, with MEMCTRL_WRAP_EN defined, generate burst word k at address {A[PAGE_BITS-1:log2 BURST_LEN], (A[log2 BURST_LEN-1:0]+k) mod BURST_LEN}, i.e. wrap inside the aligned block (critical word first).
REQ-027 SHALL, without MEMCTRL_WRAP_EN, generate burst word k at address (A+k) mod 2**PAGE_BITS (linear increment).

Structure
REQ-028 SHALL take the state enum (IDLE, READ, WRITE) and rw encoding constants from a shared package memctrl_pkg.
REQ-029 SHALL place the memory array, with a combinational read port and a synchronous write port, in sub-module memctrl_ram.

Verification
REQ-030 SHALL cover: write burst to 0x0010 with data 0xA000..0xA003, then read from 0x0010 -> oe high in T1..T4 with out=0xA000,0xA001,0xA002,0xA003.
REQ-031 SHALL cover: read from 0x0012 with BURST_LEN=4 -> with WRAP_EN, addresses 0x12,0x13,0x10,0x11; without it, 0x12..0x15.
REQ-032 SHALL cover: address cycle at 0x1234 with PAGE_ID=0 -> busy and oe stay 0 and memory is unchanged.
REQ-033 SHALL cover: read from 0x0FFE without WRAP_EN -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-034 SHALL cover: write burst with resetN=0 in T2 -> only word 0 is written; IDLE with outputs zero afterwards; a subsequent read burst succeeds.
REQ-035 SHALL cover: addrValid pulsed in T2 of a read burst, then a new read in T5 -> the mid-burst pulse is ignored and the T5 burst is served.
